// File: rtl/lock_pkg.sv
// Shared state type and field widths for the cipher-lock session sequencer.
package lock_pkg;

   localparam int unsigned FAIL_W = 3;
   localparam int unsigned SEC_W  = 4;

   typedef enum logic [2:0] {
      StIdle,
      StEntry,
      StCheck,
      StOpen,
      StLockout
   } session_state_t;

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler. A cycle with clear asserted counts as the first cycle of
// a fresh second, so tick first fires TICK_CYC-1 cycles later.
module sec_tick #(
   parameter int unsigned TICK_CYC = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(TICK_CYC - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_eff;

   always_comb begin
      cnt_eff = clear ? '0 : cnt_q;
      tick    = (cnt_eff == CntLast);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= tick ? '0 : cnt_eff + CNT_W'(1);
      end
   end

endmodule

// File: rtl/lock_session_ctrl.sv
// Session sequencer for the cipher lock: entry gating, inactivity timeout, compare
// requests, failure counting and timed lockout. AUTO_RELOCK_EN enables OPEN auto-relock.
module lock_session_ctrl
   import lock_pkg::*;
#(
   parameter int unsigned TICK_CYC    = 100_000_000,
   parameter int unsigned MAX_FAIL    = 3,
   parameter int unsigned IDLE_SEC    = 5,
   parameter int unsigned LOCKOUT_SEC = 10,
   parameter int unsigned OPEN_SEC    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_valid,
   input  logic              ascertain,
   input  logic              relock,
   input  logic              match,
   output logic              cmp_req,
   output logic              clr_entry,
   output logic              entry_en,
   output logic              locked,
   output logic              unlocked,
   output logic              alarm,
   output logic [FAIL_W-1:0] fail_times,
   output logic [SEC_W-1:0]  remain_sec
);

   if (TICK_CYC == 0 || MAX_FAIL == 0 || MAX_FAIL > 7 || IDLE_SEC == 0 || IDLE_SEC > 15 ||
       LOCKOUT_SEC == 0 || LOCKOUT_SEC > 15 || OPEN_SEC > 15) begin : g_bad_param
      $error("lock_session_ctrl: parameter out of range");
   end

   localparam logic [SEC_W-1:0]  IdleLast = SEC_W'(IDLE_SEC - 1);
   localparam logic [SEC_W-1:0]  LockSec  = SEC_W'(LOCKOUT_SEC);
   localparam logic [FAIL_W-1:0] FailLast = FAIL_W'(MAX_FAIL - 1);
`ifdef AUTO_RELOCK_EN
   localparam logic [SEC_W-1:0]  OpenLast = SEC_W'(OPEN_SEC - 1);
`endif

   session_state_t   state_q;
   logic [SEC_W-1:0] sec_q;
   logic             restart_q;
   logic             tick;
   logic             tick_clr;

   // IDLE holds the prescaler clear so a key's own cycle starts the inactivity second.
   assign tick_clr = restart_q || (state_q == StIdle) || ((state_q == StEntry) && key_valid);

   sec_tick #(
      .TICK_CYC(TICK_CYC)
   ) u_sec_tick (
      .clk  (clk),
      .rst  (rst),
      .clear(tick_clr),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         sec_q      <= '0;
         restart_q  <= 1'b0;
         cmp_req    <= 1'b0;
         clr_entry  <= 1'b0;
         entry_en   <= 1'b1;
         locked     <= 1'b1;
         unlocked   <= 1'b0;
         alarm      <= 1'b0;
         fail_times <= '0;
         remain_sec <= '0;
      end else begin
         cmp_req   <= 1'b0;
         clr_entry <= 1'b0;
         restart_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (ascertain) begin
                  state_q   <= StCheck;
                  cmp_req   <= 1'b1;
                  restart_q <= 1'b1;
               end else if (key_valid) begin
                  state_q <= StEntry;
                  sec_q   <= '0;
               end
            end
            StEntry: begin
               if (ascertain) begin
                  state_q   <= StCheck;
                  cmp_req   <= 1'b1;
                  restart_q <= 1'b1;
               end else if (key_valid) begin
                  sec_q <= '0;
               end else if (tick) begin
                  if (sec_q == IdleLast) begin
                     state_q   <= StIdle;
                     clr_entry <= 1'b1;
                     restart_q <= 1'b1;
                  end else begin
                     sec_q <= sec_q + SEC_W'(1);
                  end
               end
            end
            StCheck: begin
               // First CHECK cycle carries cmp_req; match is valid on the second.
               if (!cmp_req) begin
                  clr_entry <= 1'b1;
                  restart_q <= 1'b1;
                  if (match) begin
                     state_q    <= StOpen;
                     fail_times <= '0;
                     sec_q      <= '0;
                     locked     <= 1'b0;
                     unlocked   <= 1'b1;
                     entry_en   <= 1'b0;
                  end else if (fail_times >= FailLast) begin
                     state_q    <= StLockout;
                     fail_times <= fail_times + FAIL_W'(1);
                     remain_sec <= LockSec;
                     alarm      <= 1'b1;
                     entry_en   <= 1'b0;
                  end else begin
                     state_q    <= StIdle;
                     fail_times <= fail_times + FAIL_W'(1);
                  end
               end
            end
            StOpen: begin
               if (relock) begin
                  state_q   <= StIdle;
                  restart_q <= 1'b1;
                  locked    <= 1'b1;
                  unlocked  <= 1'b0;
                  entry_en  <= 1'b1;
`ifdef AUTO_RELOCK_EN
               end else if (tick) begin
                  if (sec_q == OpenLast) begin
                     state_q   <= StIdle;
                     restart_q <= 1'b1;
                     locked    <= 1'b1;
                     unlocked  <= 1'b0;
                     entry_en  <= 1'b1;
                  end else begin
                     sec_q <= sec_q + SEC_W'(1);
                  end
`endif
               end
            end
            StLockout: begin
               if (tick) begin
                  remain_sec <= remain_sec - SEC_W'(1);
                  if (remain_sec == SEC_W'(1)) begin
                     state_q    <= StIdle;
                     restart_q  <= 1'b1;
                     fail_times <= '0;
                     alarm      <= 1'b0;
                     entry_en   <= 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_lock_session_ctrl.sv
// Randomized bench for lock_session_ctrl against a cycle-arithmetic reference model.
module tb_lock_session_ctrl;
   timeunit 1ns;
   timeprecision 1ps;

   localparam int unsigned TICK_CYC    = 4;
   localparam int unsigned MAX_FAIL    = 3;
   localparam int unsigned IDLE_SEC    = 5;
   localparam int unsigned LOCKOUT_SEC = 10;
   localparam int unsigned OPEN_SEC    = 8;
`ifdef AUTO_RELOCK_EN
   localparam bit AutoRelock = 1'b1;
`else
   localparam bit AutoRelock = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_valid = 1'b0;
   logic       ascertain = 1'b0;
   logic       relock = 1'b0;
   logic       match = 1'b0;
   logic       cmp_req, clr_entry, entry_en, locked, unlocked, alarm;
   logic [2:0] fail_times;
   logic [3:0] remain_sec;

   lock_session_ctrl #(
      .TICK_CYC   (TICK_CYC),
      .MAX_FAIL   (MAX_FAIL),
      .IDLE_SEC   (IDLE_SEC),
      .LOCKOUT_SEC(LOCKOUT_SEC),
      .OPEN_SEC   (OPEN_SEC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .ascertain (ascertain),
      .relock    (relock),
      .match     (match),
      .cmp_req   (cmp_req),
      .clr_entry (clr_entry),
      .entry_en  (entry_en),
      .locked    (locked),
      .unlocked  (unlocked),
      .alarm     (alarm),
      .fail_times(fail_times),
      .remain_sec(remain_sec)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   // Reference model: modes plus absolute cycle stamps of the events that start timers.
   typedef enum {ModeIdle, ModeEntry, ModeCheck, ModeOpen, ModeLock} mode_t;
   mode_t m_mode = ModeIdle;
   int    m_fail = 0;
   bit    m_cmp = 1'b0;
   bit    m_clr = 1'b0;
   int    cyc = 0;
   int    last_key = 0;
   int    chk_t = 0;
   int    enter_cyc = 0;

   task automatic model_reset();
      m_mode = ModeIdle;
      m_fail = 0;
      m_cmp  = 1'b0;
      m_clr  = 1'b0;
   endtask

   // Inputs seen during cycle cyc decide the outputs of cycle cyc+1.
   task automatic model_step(input bit kv, input bit asc, input bit rl, input bit mt);
      int c;
      c = cyc;
      m_cmp = 1'b0;
      m_clr = 1'b0;
      case (m_mode)
         ModeIdle, ModeEntry: begin
            if (asc) begin
               m_mode = ModeCheck;
               chk_t  = c;
               m_cmp  = 1'b1;
            end else if (kv) begin
               m_mode   = ModeEntry;
               last_key = c;
            end else if (m_mode == ModeEntry &&
                         c + 1 == last_key + int'(IDLE_SEC * TICK_CYC)) begin
               m_mode = ModeIdle;
               m_clr  = 1'b1;
            end
         end
         ModeCheck: begin
            if (c == chk_t + 2) begin
               m_clr = 1'b1;
               if (mt) begin
                  m_mode    = ModeOpen;
                  m_fail    = 0;
                  enter_cyc = c + 1;
               end else begin
                  m_fail++;
                  if (m_fail == int'(MAX_FAIL)) begin
                     m_mode    = ModeLock;
                     enter_cyc = c + 1;
                  end else begin
                     m_mode = ModeIdle;
                  end
               end
            end
         end
         ModeOpen: begin
            if (rl) m_mode = ModeIdle;
            else if (AutoRelock && c + 1 == enter_cyc + int'(OPEN_SEC * TICK_CYC))
               m_mode = ModeIdle;
         end
         ModeLock: begin
            if (c + 1 == enter_cyc + int'(LOCKOUT_SEC * TICK_CYC)) begin
               m_mode = ModeIdle;
               m_fail = 0;
            end
         end
         default: m_mode = ModeIdle;
      endcase
      cyc = c + 1;
   endtask

   task automatic compare_all();
      int exp_rem;
      exp_rem = (m_mode == ModeLock) ?
                int'(LOCKOUT_SEC) - (cyc - enter_cyc) / int'(TICK_CYC) : 0;
      check_eq("cmp_req", 32'(cmp_req), 32'(m_cmp));
      check_eq("clr_entry", 32'(clr_entry), 32'(m_clr));
      check_eq("entry_en", 32'(entry_en), 32'(m_mode != ModeOpen && m_mode != ModeLock));
      check_eq("locked", 32'(locked), 32'(m_mode != ModeOpen));
      check_eq("unlocked", 32'(unlocked), 32'(m_mode == ModeOpen));
      check_eq("alarm", 32'(alarm), 32'(m_mode == ModeLock));
      check_eq("fail_times", 32'(fail_times), 32'(m_fail));
      check_eq("remain_sec", 32'(remain_sec), 32'(exp_rem));
   endtask

   task automatic step(input bit kv, input bit asc, input bit rl, input bit mt);
      @(negedge clk);
      key_valid = kv;
      ascertain = asc;
      relock    = rl;
      match     = mt;
      @(posedge clk);
      #1;
      model_step(kv, asc, rl, mt);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
   endtask

   task automatic confirm(input bit mt);
      step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      step(1'b0, 1'b0, 1'b0, mt);
   endtask

   task automatic check_reset_values(input string pfx);
      check_eq({pfx, "_cmp_req"}, 32'(cmp_req), 32'd0);
      check_eq({pfx, "_clr_entry"}, 32'(clr_entry), 32'd0);
      check_eq({pfx, "_entry_en"}, 32'(entry_en), 32'd1);
      check_eq({pfx, "_locked"}, 32'(locked), 32'd1);
      check_eq({pfx, "_unlocked"}, 32'(unlocked), 32'd0);
      check_eq({pfx, "_alarm"}, 32'(alarm), 32'd0);
      check_eq({pfx, "_fail_times"}, 32'(fail_times), 32'd0);
      check_eq({pfx, "_remain_sec"}, 32'(remain_sec), 32'd0);
   endtask

   // Raise rst between clock edges and check outputs before the next edge.
   task automatic async_reset_check();
      @(negedge clk);
      key_valid = 1'b0;
      ascertain = 1'b0;
      relock    = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_reset_values("async_rst");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit quiet;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Successful confirm, OPEN held (or auto-relocked), then manual relock.
      idle(2);
      confirm(1'b1);
      idle(100);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);

      // Three failures into lockout; keypad and confirm activity must be ignored.
      for (int k = 0; k < 3; k++) begin
         confirm(1'b0);
         idle(2);
      end
      for (int i = 0; i < 45; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      idle(3);

      // Keys every 3 cycles keep ENTRY alive, then the inactivity timeout.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         idle(2);
         step(1'b1, 1'b0, 1'b0, 1'b0);
      end
      idle(25);

      // A key on the expiry cycle restarts the timer.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(18);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(25);

      // Lockout again, then asynchronous reset mid-lockout.
      for (int k = 0; k < 3; k++) confirm(1'b0);
      idle(10);
      async_reset_check();
      idle(3);

      // Randomized traffic with quiet stretches to let timers expire.
      for (int i = 0; i < 3000; i++) begin
         quiet = ((i / 64) % 4) == 3;
         step(!quiet && ($urandom_range(0, 7) == 0),
              !quiet && ($urandom_range(0, 19) == 0),
              $urandom_range(0, 29) == 0,
              1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lock_session_ctrl.md
# lock_session_ctrl

Session sequencer for the cipher lock. It sits between the keypad scanner and the password comparator. It gates digit entry, times out stale entries, and issues one compare request per confirm press. It also counts failed attempts and enforces a timed lockout with alarm after repeated failures. It owns `locked`/`unlocked`/`fail_times` at top level; the password block becomes a pure store/compare datapath.

## Interface
- `TICK_CYC`, 100_000_000 — clock cycles per 1 s tick (100 MHz board clock); benches use 4
- `MAX_FAIL`, 3 — failures that trigger lockout; legal 1..7
- `IDLE_SEC`, 5 — entry inactivity timeout, seconds
- `LOCKOUT_SEC`, 10 — lockout duration, seconds; legal 1..15
- `OPEN_SEC`, 8 — auto-relock delay, seconds (only with `AUTO_RELOCK_EN`)
- `clk` in 1 — system clock
- `rst` in 1 — reset, asynchronous, active-high
- `key_valid` in 1 — one-cycle pulse per accepted digit from keypad scanner
- `ascertain` in 1 — one-cycle confirm pulse (debounced S5)
- `relock` in 1 — one-cycle manual relock pulse
- `match` in 1 — comparator result, valid the cycle after `cmp_req`
- `cmp_req` out 1 — one-cycle compare request to password datapath
- `clr_entry` out 1 — one-cycle pulse clearing entered digits
- `entry_en` out 1 — datapath may accept digits
- `locked` out 1, `unlocked` out 1 — lock status, mutually exclusive
- `alarm` out 1 — high throughout lockout
- `fail_times` out 3 — consecutive failures, saturates at `MAX_FAIL`
- `remain_sec` out 4 — lockout seconds remaining, 0 outside lockout

## Operation
- Reset values: state IDLE, `locked`=1, `entry_en`=1, all other outputs 0.
- States: IDLE, ENTRY, CHECK, OPEN, LOCKOUT. All outputs are registered.
- IDLE:
  - `key_valid` → ENTRY.
  - `ascertain` → CHECK. An empty entry is compared and normally fails.
- ENTRY:
  - `key_valid` restarts the inactivity timer.
  - `IDLE_SEC` ticks with no key → IDLE, with `clr_entry` pulsed.
  - `ascertain` → CHECK.
- Entering CHECK: `cmp_req` is pulsed. The following cycle samples `match` and leaves CHECK with `clr_entry` pulsed:
  - `match`=1: → OPEN, `fail_times`←0.
  - `match`=0 and `fail_times`+1 < `MAX_FAIL`: increment `fail_times`, → IDLE.
  - `match`=0 and `fail_times`+1 == `MAX_FAIL`: increment `fail_times`, → LOCKOUT with `remain_sec`←`LOCKOUT_SEC`, `alarm`=1.
- OPEN: `unlocked`=1, `locked`=0, `entry_en`=0. `relock` → IDLE.
- LOCKOUT: `entry_en`=0. Each tick decrements `remain_sec`. The tick taking it to 0 also → IDLE with `fail_times`←0 and `alarm`←0.
- Inputs not listed for a state are ignored. `ascertain` is ignored in CHECK, OPEN and LOCKOUT.
- Simultaneous events in ENTRY:
  - `ascertain` beats `key_valid`.
  - `key_valid` beats a timeout tick in the same cycle.

## Timing
- Tick prescaler clears on every state entry. The first tick fires `TICK_CYC` cycles after entry.
- Timer durations:
  - LOCKOUT lasts exactly `LOCKOUT_SEC`×`TICK_CYC` cycles.
  - The ENTRY timeout fires `IDLE_SEC`×`TICK_CYC` cycles after the last key.
- `ascertain` at cycle t:
  - `cmp_req`=1 at t+1.
  - `match` is sampled at t+2.
  - New state and `clr_entry` appear at t+3.
- Status outputs change in the same cycle as the state register.
- `rst` mid-operation immediately restores reset values, including clearing `fail_times` and `alarm`.

## Configuration
- `AUTO_RELOCK_EN` defined: OPEN returns to IDLE after `OPEN_SEC` ticks.
  - `relock` still relocks early.
  - A `relock` coinciding with the expiry tick gives a single transition.
- Undefined: OPEN is left only by `relock` or `rst`. The `OPEN_SEC` parameter is unused.

## Structure
- Package `lock_pkg`:
  - state enum `session_state_t`
  - `FAIL_W`=3 and `SEC_W`=4 width constants
- Sub-module `sec_tick`: prescaler with synchronous clear input and one-cycle `tick` output. One instance is shared by all timers.
- The seconds counter, fail counter and FSM stay in `lock_session_ctrl`.

## Test plan
All scenarios use `TICK_CYC`=4.
- Reset, then `ascertain`, `match`=1 → `cmp_req` at +1, `unlocked`=1 at +3, `fail_times`=0, `clr_entry` one pulse.
- Three confirms with `match`=0 → `fail_times` reads 1, 2, 3:
  - third confirm: `alarm`=1, `remain_sec`=10, `entry_en`=0.
  - `remain_sec` decrements every 4 cycles.
  - IDLE reached 40 cycles after LOCKOUT entry, with `fail_times`=0 and `alarm`=0.
- ENTRY keys every 3 cycles keep ENTRY alive:
  - keys stop → `clr_entry` and IDLE exactly 20 cycles after the last key.
  - a `key_valid` on the expiry cycle restarts the timer instead.
- During LOCKOUT, `key_valid` and `ascertain` → no `cmp_req`, no state change.
- `rst` asserted mid-LOCKOUT → `locked`=1, `alarm`=0, `fail_times`=0, `remain_sec`=0 immediately (asynchronous).
- `AUTO_RELOCK_EN` → OPEN for 32 cycles, then IDLE. Without the macro → OPEN held for 100 cycles until `relock`.
